// File: rtl/hazard_tracker.sv
// hazard_tracker: destination-register bookkeeping for the EX, MEM and WB
// stages of a 5-stage MIPS pipeline. It produces the Rd/RegWrite pairs used
// by forwarding and by the register-file write port. It also raises Stall for
// load-use hazards and for HI/LO accesses while the mult/div unit is busy.
module hazard_tracker #(
    parameter int unsigned MULDIV_CYCLES = 4   // legal range 1..15
) (
    input  logic       Clk,
    input  logic       Rst_n,
    // Instruction currently in ID
    input  logic [4:0] Rs_Id,
    input  logic [4:0] Rt_Id,
    input  logic       UsesRs_Id,
    input  logic       UsesRt_Id,
    input  logic [4:0] Rd_Id,
    input  logic       RegWrite_Id,
    input  logic       MemRead_Id,
    input  logic       MultDiv_Id,
    input  logic       UsesHiLo_Id,
    input  logic       Flush,
    // Hazard output
    output logic       Stall,
    // Stage destination records
    output logic [4:0] Rd_Ex,
    output logic [4:0] Rd_Mem,
    output logic [4:0] Rd_Wb,
    output logic       RegWrite_Ex,
    output logic       RegWrite_Mem,
    output logic       RegWrite_Wb,
    output logic       MemRead_Ex,
    output logic       HiLoBusy
);

    // Value loaded into the busy counter when a mult/div is accepted.
    localparam logic [3:0] BUSY_LOAD = 4'(MULDIV_CYCLES);

    // EX keeps the load flag for load-use detection; later stages need only
    // the destination and its write enable.
    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } ex_rec_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
    } late_rec_t;

    ex_rec_t    ex_q;
    ex_rec_t    ex_d;
    late_rec_t  mem_q;
    late_rec_t  wb_q;
    logic [3:0] busy_q;
    logic [3:0] busy_d;

    logic       rs_match;
    logic       rt_match;
    logic       load_use_hazard;
    logic       hilo_hazard;
    logic       accept;
    logic       id_reg_write;

    // Hazard detection: compares only ID inputs with registered EX/counter
    // state, so Flush can gate Stall without forming a loop.
    always_comb begin
        // NOTE: every always_comb output is given a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        rs_match        = 1'b0;
        rt_match        = 1'b0;
        load_use_hazard = 1'b0;
        hilo_hazard     = 1'b0;
        Stall           = 1'b0;
        accept          = 1'b0;

        // A load's destination is never $0 (RegWrite is cleared on capture
        // and MemRead depends on it), so a match on $0 cannot trigger here.
        rs_match        = UsesRs_Id && (Rs_Id == ex_q.rd);
        rt_match        = UsesRt_Id && (Rt_Id == ex_q.rd);
        load_use_hazard = ex_q.mem_read && (rs_match || rt_match);

        // The counter's current value is used: a dependent HI/LO instruction
        // waits until the counter reads 0.
        hilo_hazard     = (busy_q != 4'd0) && (UsesHiLo_Id || MultDiv_Id);

        // Flush wins over any hazard: the squashed instruction must not hold
        // the front end.
        Stall           = (load_use_hazard || hilo_hazard) && !Flush;
        accept          = !Stall && !Flush;
    end

    // Next EX record: the ID instruction when accepted, otherwise a bubble.
    always_comb begin
        ex_d         = '0;
        id_reg_write = RegWrite_Id && (Rd_Id != 5'd0);
        if (accept) begin
            ex_d.rd        = Rd_Id;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = MemRead_Id && id_reg_write;
        end
    end

    // Next HI/LO busy count: reload on an accepted mult/div, else count down
    // to zero and hold there.
    always_comb begin
        busy_d = busy_q;
        if (accept && MultDiv_Id) begin
            busy_d = BUSY_LOAD;
        end else if (busy_q != 4'd0) begin
            busy_d = busy_q - 4'd1;
        end
    end

    // Pipeline records and busy counter; reset discards everything in flight.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ex_q   <= '0;
            mem_q  <= '0;
            wb_q   <= '0;
            busy_q <= 4'd0;
        end else begin
            // NOTE: non-blocking assignments let MEM take the old EX and WB
            // the old MEM in the same edge, exactly like the real pipeline
            // registers; blocking ones would collapse the stages.
            ex_q   <= ex_d;
            mem_q  <= '{rd: ex_q.rd, reg_write: ex_q.reg_write};
            wb_q   <= mem_q;
            busy_q <= busy_d;
        end
    end

    // Stage records to the forwarding unit and register-file write port.
    assign Rd_Ex        = ex_q.rd;
    assign RegWrite_Ex  = ex_q.reg_write;
    assign MemRead_Ex   = ex_q.mem_read;
    assign Rd_Mem       = mem_q.rd;
    assign RegWrite_Mem = mem_q.reg_write;
    assign Rd_Wb        = wb_q.rd;
    assign RegWrite_Wb  = wb_q.reg_write;
    assign HiLoBusy     = (busy_q != 4'd0);

endmodule
